// File: rtl/coinc_timer_pkg.sv
// ---------------------------------------------------------------------------
// coinc_timer_pkg : window FSM state type and default parameters  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package coinc_timer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OPEN = 1'b1
  } win_state_e;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DEB_CYCLES = 16;
  localparam int DEF_WIN_CYCLES = 100;
  localparam int DEF_COUNT_W    = 8;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/coinc_channel.sv
// ---------------------------------------------------------------------------
// coinc_channel : synchroniser, debouncer and retriggerable window FSM  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module coinc_channel
  import coinc_timer_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int WIN_CYCLES = DEF_WIN_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic en,
  output logic deb_out,
  output logic open_win
);

  localparam int DEB_W = cnt_width(DEB_CYCLES);
  localparam int WIN_W = cnt_width(WIN_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_out_d;
  logic             rise;
  win_state_e       state;
  logic [WIN_W-1:0] win_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // The mismatch streak reaching DEB_CYCLES flips the level and restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else if (sync2 == deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
      deb     <= ~deb;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  assign deb_out = deb & en;
  assign rise    = deb_out & ~deb_out_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_out_d <= 1'b0;
      state     <= IDLE;
      win_cnt   <= '0;
    end else begin
      deb_out_d <= deb_out;
      if (!en) begin
        state   <= IDLE;
        win_cnt <= '0;
      end else if (rise) begin
        state   <= OPEN;
        win_cnt <= WIN_W'(WIN_CYCLES);
      end else if (state == OPEN) begin
        if (win_cnt == WIN_W'(1)) begin
          state   <= IDLE;
          win_cnt <= '0;
        end else begin
          win_cnt <= win_cnt - WIN_W'(1);
        end
      end
    end
  end

  assign open_win = (state == OPEN);

endmodule

`default_nettype wire

// File: rtl/coincidence_led_timer.sv
// ---------------------------------------------------------------------------
// coincidence_led_timer : multi-channel button coincidence detector with LEDs
// Optional event counter enabled by macro COINC_COUNT_EN          | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module coincidence_led_timer
  import coinc_timer_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int WIN_CYCLES = DEF_WIN_CYCLES,
  parameter int COUNT_W    = DEF_COUNT_W
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic [NUM_CH-1:0]  btn_in,
  input  logic [NUM_CH-1:0]  ch_en,
  output logic [NUM_CH-1:0]  deb_out,
  output logic [NUM_CH-1:0]  led,
  output logic               coinc_pulse,
  output logic [COUNT_W-1:0] coinc_count
);

  logic [NUM_CH-1:0] open_win;
  logic [NUM_CH-1:0] hit;
  logic              hit_any;
  logic              hit_any_d;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      coinc_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .WIN_CYCLES (WIN_CYCLES)
      ) u_ch (
        .clk      (clkin),
        .rst_n    (reset),
        .btn      (btn_in[i]),
        .en       (ch_en[i]),
        .deb_out  (deb_out[i]),
        .open_win (open_win[i])
      );
    end
  endgenerate

  // A channel hits when its window is open and some other channel is pressed.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = open_win[i] & (|(deb_out & ~(NUM_CH'(1) << i)));
    end
  end

  assign hit_any = |hit;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      led         <= '0;
      hit_any_d   <= 1'b0;
      coinc_pulse <= 1'b0;
    end else begin
      led         <= deb_out | hit;
      hit_any_d   <= hit_any;
      coinc_pulse <= hit_any & ~hit_any_d;
    end
  end

`ifdef COINC_COUNT_EN
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      coinc_count <= '0;
    end else if (hit_any && !hit_any_d && !(&coinc_count)) begin
      coinc_count <= coinc_count + COUNT_W'(1);
    end
  end
`else
  assign coinc_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_coincidence_led_timer.sv
// ---------------------------------------------------------------------------
// tb_coincidence_led_timer : vector table, directed corner sequences and
// random stimulus against a timestamp-based reference model     | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_coincidence_led_timer;

  localparam int NCH = 4;
  localparam int DEB = 4;
  localparam int WIN = 10;
  localparam int CW  = 8;
`ifdef COINC_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NCH-1:0] btn = '0;
  logic [NCH-1:0] en = 4'hF;
  logic [NCH-1:0] deb_out;
  logic [NCH-1:0] led;
  logic           coinc_pulse;
  logic [CW-1:0]  coinc_count;

  coincidence_led_timer #(
    .NUM_CH     (NCH),
    .DEB_CYCLES (DEB),
    .WIN_CYCLES (WIN),
    .COUNT_W    (CW)
  ) dut (
    .clkin       (clk),
    .reset       (rst_n),
    .btn_in      (btn),
    .ch_en       (en),
    .deb_out     (deb_out),
    .led         (led),
    .coinc_pulse (coinc_pulse),
    .coinc_count (coinc_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: debounce as a mismatch streak, windows as expiry timestamps.
  logic [NCH-1:0] m_s1, m_s2, m_deb, m_dop, m_led;
  logic           m_pulse, m_hprev;
  int             m_count;
  int             m_streak[NCH];
  int             m_open_until[NCH];
  int             cyc = 0;

  int             pulses, first_pulse, tick_no;
  logic [NCH-1:0] seen_led, seen_deb;

  typedef struct {
    logic [NCH-1:0] btn;
    logic [NCH-1:0] deb_out;
    logic [NCH-1:0] led;
    logic           pulse;
  } vec_t;
  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_dop = '0; m_led = '0;
    m_pulse = 1'b0; m_hprev = 1'b0; m_count = 0;
    for (int i = 0; i < NCH; i++) begin
      m_streak[i] = 0;
      m_open_until[i] = -1000;
    end
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    logic [NCH-1:0] dout, hit, others;
    logic hany;
    dout = m_deb & en;
    for (int i = 0; i < NCH; i++) begin
      others = dout;
      others[i] = 1'b0;
      hit[i] = ((cyc - 1) <= m_open_until[i]) && (others != '0);
    end
    hany = |hit;
    m_led   = dout | hit;
    m_pulse = hany && !m_hprev;
    m_hprev = hany;
    if (m_pulse && CNT_EN && m_count < (2**CW - 1)) m_count++;
    for (int i = 0; i < NCH; i++) begin
      if (!en[i]) m_open_until[i] = -1000;
      else if (dout[i] && !m_dop[i]) m_open_until[i] = cyc + WIN - 1;
    end
    m_dop = dout;
    for (int i = 0; i < NCH; i++) begin
      if (m_s2[i] == m_deb[i]) m_streak[i] = 0;
      else begin
        m_streak[i]++;
        if (m_streak[i] >= DEB) begin
          m_deb[i] = ~m_deb[i];
          m_streak[i] = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  task automatic tick();
    cyc++;
    model_step();
    @(posedge clk);
    #1;
    tick_no++;
    check("cycle", {15'd0, deb_out, led, coinc_pulse, coinc_count},
          {15'd0, m_deb & en, m_led, m_pulse, CW'(m_count)});
    if (coinc_pulse) begin
      pulses++;
      if (first_pulse < 0) first_pulse = tick_no;
    end
    seen_led |= led;
    seen_deb |= deb_out;
  endtask

  task automatic clr_seen();
    pulses = 0; first_pulse = -1; tick_no = 0;
    seen_led = '0; seen_deb = '0;
  endtask

  // Asynchronous assertion checked before any clock edge arrives.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_async", {15'd0, deb_out, led, coinc_pulse, coinc_count}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_seen();
  endtask

  initial begin
    for (int n = 1; n <= 18; n++) begin
      tbl[n-1].btn     = (n <= 10) ? 4'h1 : 4'h0;
      tbl[n-1].deb_out = (n >= 6 && n <= 15) ? 4'h1 : 4'h0;
      tbl[n-1].led     = (n >= 7 && n <= 16) ? 4'h1 : 4'h0;
      tbl[n-1].pulse   = 1'b0;
    end

    model_reset();
    #2;
    do_reset();

    // Single press and release of channel 0.
    foreach (tbl[k]) begin
      btn = tbl[k].btn;
      tick();
      check("table", {23'd0, deb_out, led, coinc_pulse},
            {23'd0, tbl[k].deb_out, tbl[k].led, tbl[k].pulse});
    end

    // Coincidence: ch1 debounced rise 5 cycles after ch0.
    do_reset();
    btn = 4'h1;
    repeat (5) tick();
    btn = 4'h3;
    repeat (15) tick();
    check("coinc_pulses", pulses, 1);
    check("coinc_pulse_tick", first_pulse, 12);
    check("coinc_led", {28'd0, led}, 32'h3);
    check("coinc_count", {24'd0, coinc_count}, CNT_EN ? 32'd1 : 32'd0);

    // Window expiry: ch1 rises 11 cycles after ch0 (ch0 already released).
    do_reset();
    btn = 4'h1;
    repeat (6) tick();
    btn = 4'h0;
    repeat (5) tick();
    btn = 4'h2;
    repeat (19) tick();
    check("expiry_pulses", pulses, 0);
    check("expiry_count", {24'd0, coinc_count}, 32'd0);
    check("expiry_deb1", {31'd0, deb_out[1]}, 32'd1);

    // Bounce on channel 2.
    do_reset();
    for (int t = 0; t < 20; t++) begin
      btn = ((t / 2) % 2 == 0) ? 4'h4 : 4'h0;
      tick();
    end
    btn = 4'h0;
    repeat (6) tick();
    check("bounce_deb2", {31'd0, seen_deb[2]}, 32'd0);
    check("bounce_led2", {31'd0, seen_led[2]}, 32'd0);

    // Masked channel 3 held, 300 paired presses on channels 0 and 1.
    do_reset();
    en = 4'h7;
    for (int r = 0; r < 300; r++) begin
      btn = 4'hB;
      repeat (8) tick();
      btn = 4'h8;
      repeat (8) tick();
    end
    check("sat_pulses", pulses, 300);
    check("mask_led3", {31'd0, seen_led[3]}, 32'd0);
    check("sat_count", {24'd0, coinc_count}, CNT_EN ? 32'd255 : 32'd0);
    en = 4'hF;

    // Reset three cycles into ch0's window, then a lone ch1 press.
    do_reset();
    btn = 4'h1;
    repeat (9) tick();
    check("pre_reset_deb0", {31'd0, deb_out[0]}, 32'd1);
    btn = 4'h0;
    do_reset();
    btn = 4'h2;
    repeat (12) tick();
    check("post_reset_pulses", pulses, 0);

    // Random stimulus with occasional mask changes and resets.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < NCH; b++)
        if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 99) == 0)
        en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
